// File: rtl/gauss_pkg.sv
// gauss_pkg: shared constants for the 3x3 Gaussian sum pipeline
package gauss_pkg;
    localparam int PIX_W_DEF  = 8;
    localparam int K_CORNER   = 0;
    localparam int K_EDGE     = 1;
    localparam int K_CENTRE   = 2;
    localparam int NORM_SHIFT = 4;
    localparam int ROUND_BIAS = 8;
    localparam int WIN_TAPS   = 9;

    function automatic int acc_width(input int pix_w);
        return pix_w + NORM_SHIFT;
    endfunction

    localparam int ACC_W = acc_width(PIX_W_DEF);
endpackage

// File: rtl/gauss_cla_add.sv
// gauss_cla_add: W-bit carry-lookahead adder built from chained 4-bit slices
module gauss_cla_add #(
    parameter int W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] sum,
    output logic         cout
);
    logic [W-1:0] g;
    logic [W-1:0] p;
    logic [W:0]   c;

    assign g = a & b;
    assign p = a ^ b;

    // every carry inside a slice is resolved from that slice's carry-in; slice carries chain
    always_comb begin
        logic t;
        t = 1'b0;
        c = '0;
        c[0] = cin;
        for (int i = 0; i < W; i += 4) begin
            for (int j = i; j < i + 4 && j < W; j++) begin
                t = c[i];
                for (int k = i; k <= j; k++) t = g[k] | (p[k] & t);
                c[j+1] = t;
            end
        end
    end

    assign sum  = p ^ c[W-1:0];
    assign cout = c[W];
endmodule

// File: rtl/gauss3x3_sum_pipe.sv
// gauss3x3_sum_pipe: 3-stage weighted-sum and /16 normalise for a 3x3 Gaussian window
module gauss3x3_sum_pipe
    import gauss_pkg::*;
#(
    parameter int PIX_W = 8,
    parameter bit ROUND = 1'b1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [WIN_TAPS*PIX_W-1:0] in_win,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [PIX_W-1:0]          out_pix,
    output logic                      busy
);
    localparam int AW = acc_width(PIX_W);
    localparam int RB = $clog2(ROUND_BIAS);

    logic             adv, v1, v2, v3;
    logic [PIX_W-1:0] p [WIN_TAPS];
    logic [PIX_W:0]   ca_n, cb_n, ea_n, eb_n, ca, cb, ea, eb;
    logic [PIX_W+1:0] cc, cs_n, eab_n, cs, cc2;
    logic [PIX_W+2:0] es, t1_n;
    logic [AW-1:0]    tot_n;
    logic [PIX_W-1:0] pix_n;
    logic             rnd_c;
    logic             unused_bits;

    genvar k;
    for (k = 0; k < WIN_TAPS; k++) begin : g_tap
        assign p[k] = in_win[k*PIX_W +: PIX_W];
    end

    gauss_cla_add #(.W(PIX_W)) u_ca (.a(p[0]), .b(p[2]), .cin(1'b0), .sum(ca_n[PIX_W-1:0]), .cout(ca_n[PIX_W]));
    gauss_cla_add #(.W(PIX_W)) u_cb (.a(p[6]), .b(p[8]), .cin(1'b0), .sum(cb_n[PIX_W-1:0]), .cout(cb_n[PIX_W]));
    gauss_cla_add #(.W(PIX_W)) u_ea (.a(p[1]), .b(p[3]), .cin(1'b0), .sum(ea_n[PIX_W-1:0]), .cout(ea_n[PIX_W]));
    gauss_cla_add #(.W(PIX_W)) u_eb (.a(p[5]), .b(p[7]), .cin(1'b0), .sum(eb_n[PIX_W-1:0]), .cout(eb_n[PIX_W]));

    gauss_cla_add #(.W(PIX_W+1)) u_cs  (.a(ca), .b(cb), .cin(1'b0), .sum(cs_n[PIX_W:0]),  .cout(cs_n[PIX_W+1]));
    gauss_cla_add #(.W(PIX_W+1)) u_eab (.a(ea), .b(eb), .cin(1'b0), .sum(eab_n[PIX_W:0]), .cout(eab_n[PIX_W+1]));

    gauss_cla_add #(.W(PIX_W+2)) u_t1  (.a(cs), .b(cc2),  .cin(1'b0), .sum(t1_n[PIX_W+1:0]), .cout(t1_n[PIX_W+2]));
    gauss_cla_add #(.W(PIX_W+3)) u_tot (.a(es), .b(t1_n), .cin(1'b0), .sum(tot_n[AW-2:0]),   .cout(tot_n[AW-1]));

    // adding the half-LSB bias then dropping NORM_SHIFT bits equals carrying in the bit just below the cut
    gauss_cla_add #(.W(PIX_W)) u_rnd (
        .a(tot_n[AW-1:NORM_SHIFT]), .b('0), .cin(ROUND && tot_n[RB]), .sum(pix_n), .cout(rnd_c)
    );

    assign unused_bits = ^{tot_n[RB-1:0], rnd_c};
    assign adv         = ~v3 | out_ready;
    assign in_ready    = adv;
    assign out_valid   = v3;
    assign busy        = v1 | v2 | v3;

    // stage 1: pairwise corner/edge sums and weighted centre
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            {ca, cb, ea, eb, cc, v1} <= '0;
        end else if (adv) begin
            ca <= ca_n;
            cb <= cb_n;
            ea <= ea_n;
            eb <= eb_n;
            cc <= (PIX_W+2)'(p[4]) << K_CENTRE;
            v1 <= in_valid;
        end
    end

    // stage 2: corner total, weighted edge total, centre carried along
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            {cs, es, cc2, v2} <= '0;
        end else if (adv) begin
            cs  <= cs_n;
            es  <= (PIX_W+3)'(eab_n) << K_EDGE;
            cc2 <= cc;
            v2  <= v1;
        end
    end

    // stage 3: full sum, normalise, hold for the consumer
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            {out_pix, v3} <= '0;
        end else if (adv) begin
            out_pix <= pix_n;
            v3      <= v2;
        end
    end
endmodule

// File: tb/tb_gauss3x3_sum_pipe.sv
// tb_gauss3x3_sum_pipe: scoreboard bench for the Gaussian sum pipeline (rounding and truncating builds)
module tb_gauss3x3_sum_pipe;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b1;
    logic [71:0] in_win = '0;
    logic        in_ready, out_valid, busy;
    logic        in_ready_t, out_valid_t, busy_t;
    logic [7:0]  out_pix, out_pix_t;
    logic [71:0] wa;
    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    bit          chk_lat = 1'b1;
    logic        held = 1'b0;
    logic [7:0]  held_pix = '0;

    typedef struct {
        logic [7:0] e;
        logic [7:0] et;
        int         c;
    } sb_t;

    sb_t q[$];
    sb_t s;

    gauss3x3_sum_pipe #(.PIX_W(8), .ROUND(1'b1)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_win(in_win),
        .out_valid(out_valid), .out_ready(out_ready), .out_pix(out_pix), .busy(busy)
    );

    gauss3x3_sum_pipe #(.PIX_W(8), .ROUND(1'b0)) u_dut_t (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_t), .in_win(in_win),
        .out_valid(out_valid_t), .out_ready(out_ready), .out_pix(out_pix_t), .busy(busy_t)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    function automatic logic [7:0] model(input logic [71:0] w, input bit rnd);
        int wt[9] = '{1, 2, 1, 2, 4, 2, 1, 2, 1};
        int t = 0;
        for (int i = 0; i < 9; i++) t += wt[i] * int'(w[i*8 +: 8]);
        if (rnd) t += 8;
        return 8'(t >> 4);
    endfunction

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", n, a, e);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [71:0] w);
        sb_t x;
        int  n = 0;
        in_valid = 1'b1;
        in_win = w;
        while (1) begin
            @(negedge clk);
            if (in_ready) begin
                x.e = model(w, 1'b1);
                x.et = model(w, 1'b0);
                x.c = cyc;
                q.push_back(x);
                @(posedge clk);
                #1;
                return;
            end
            @(posedge clk);
            #1;
            if (++n > 100) begin
                chk("accept_timeout", 32'(in_ready), 1);
                return;
            end
        end
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 50) begin
            tick(1);
            n++;
        end
        chk("drain", q.size(), 0);
    endtask

    // monitor: pops the scoreboard on every output transfer, watches held outputs for stability
    always @(negedge clk) begin
        if (rst_n && out_valid && held) chk("hold_stable", 32'(out_pix), 32'(held_pix));
        if (rst_n && out_valid && out_ready) begin
            if (q.size() == 0) begin
                chk("unexpected_out", 32'(out_valid), 0);
            end else begin
                s = q.pop_front();
                chk("pix_round", 32'(out_pix), 32'(s.e));
                chk("pix_trunc", 32'(out_pix_t), 32'(s.et));
                chk("valid_trunc", 32'(out_valid_t), 1);
                if (chk_lat) chk("latency", cyc - s.c, 3);
            end
        end
        held = rst_n && out_valid && !out_ready;
        held_pix = out_pix;
    end

    initial begin
        tick(2);
        rst_n = 1'b1;
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_out_pix", 32'(out_pix), 0);
        chk("rst_in_ready", 32'(in_ready), 1);

        wa = '1;
        send(wa);
        in_valid = 1'b0;
        chk("busy_in_flight", 32'(busy), 1);
        drain();

        wa = '0;
        wa[39:32] = 8'd16;
        send(wa);
        for (int i = 0; i < 9; i++) wa[i*8 +: 8] = 8'(10 * i);
        send(wa);
        in_valid = 1'b0;
        drain();

        wa = '0;
        wa[7:0] = 8'd8;
        send(wa);
        wa[7:0] = 8'd7;
        send(wa);
        in_valid = 1'b0;
        drain();

        chk_lat = 1'b0;
        out_ready = 1'b0;
        fork
            begin
                for (int i = 0; i < 6; i++) begin
                    wa = '0;
                    wa[39:32] = 8'(16 * (i + 1));
                    wa[7:0] = 8'(i * 3);
                    send(wa);
                end
                in_valid = 1'b0;
            end
            begin
                tick(8);
                chk("stall_in_ready", 32'(in_ready), 0);
                chk("stall_accepts", q.size(), 3);
                chk("stall_out_valid", 32'(out_valid), 1);
                out_ready = 1'b1;
            end
        join
        drain();

        chk_lat = 1'b1;
        for (int i = 0; i < 20; i++) begin
            wa[31:0] = $urandom();
            wa[63:32] = $urandom();
            wa[71:64] = 8'($urandom());
            send(wa);
        end
        in_valid = 1'b0;
        drain();

        wa = '1;
        send(wa);
        wa = '0;
        wa[39:32] = 8'd200;
        send(wa);
        in_valid = 1'b0;
        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
        q.delete();
        chk("midrst_out_valid", 32'(out_valid), 0);
        chk("midrst_busy", 32'(busy), 0);
        chk("midrst_out_pix", 32'(out_pix), 0);
        tick(5);
        chk("midrst_no_stale", 32'(busy), 0);
        for (int i = 0; i < 9; i++) wa[i*8 +: 8] = 8'(10 * i);
        send(wa);
        in_valid = 1'b0;
        drain();

        chk("scoreboard_empty", q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
